// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator: fill/drain, running dot, ping-pong and blink,
// paced by a DIV-clock prescaler with pause, direction and step/cycle pulses.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25000000,
  parameter int CNT_W = $clog2(DIV) + 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             step_tick,
  output logic             cycle_done
);

  typedef enum logic {
    BOUNCE_LEFT  = 1'b0,
    BOUNCE_RIGHT = 1'b1
  } bounce_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0] ONE_LSB  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONE_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [1:0]       mode_q, mode_d;
  bounce_e          bounce_q, bounce_d;
  logic             step_tick_q, step_tick_d;
  logic             cycle_done_q, cycle_done_d;

  logic [WIDTH-1:0] step_pat;
  bounce_e          step_bounce;
  logic             step_done;

  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m, input logic d);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      2'd1:    s = d ? ONE_MSB : ONE_LSB;
      2'd2:    s = ONE_LSB;
      default: s = '0;
    endcase
    return s;
  endfunction

  // Pattern value (and ping-pong direction) that the next step would produce.
  always_comb begin
    step_pat    = pat_q;
    step_bounce = bounce_q;
    step_done   = 1'b0;
    case (mode_q)
      2'd0: begin
        step_pat  = dir ? {~pat_q[0], pat_q[WIDTH-1:1]}
                        : {pat_q[WIDTH-2:0], ~pat_q[WIDTH-1]};
        step_done = (step_pat == '0);
      end
      2'd1: begin
        step_pat  = dir ? {pat_q[0], pat_q[WIDTH-1:1]}
                        : {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        step_done = (step_pat == (dir ? ONE_MSB : ONE_LSB));
      end
      2'd2: begin
        if (bounce_q == BOUNCE_LEFT) begin
          if (pat_q[WIDTH-1]) begin
            step_bounce = BOUNCE_RIGHT;
            step_pat    = pat_q >> 1;
          end else begin
            step_pat    = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            step_bounce = BOUNCE_LEFT;
            step_pat    = pat_q << 1;
          end else begin
            step_pat    = pat_q >> 1;
          end
        end
        step_done = step_pat[0];
      end
      default: begin
        step_pat  = ~pat_q;
        step_done = (step_pat == '0);
      end
    endcase
  end

  // A mode change reloads the seed ahead of any step, even while paused.
  always_comb begin
    cnt_d        = cnt_q;
    pat_d        = pat_q;
    mode_d       = mode_q;
    bounce_d     = bounce_q;
    step_tick_d  = 1'b0;
    cycle_done_d = 1'b0;
    if (mode != mode_q) begin
      pat_d    = seed_of(mode, dir);
      cnt_d    = '0;
      bounce_d = BOUNCE_LEFT;
      mode_d   = mode;
    end else if (!pause) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        pat_d        = step_pat;
        bounce_d     = step_bounce;
        step_tick_d  = 1'b1;
        cycle_done_d = step_done;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      cnt_q        <= '0;
      pat_q        <= '0;
      mode_q       <= 2'd0;
      bounce_q     <= BOUNCE_LEFT;
      step_tick_q  <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      mode_q       <= mode_d;
      bounce_q     <= bounce_d;
      step_tick_q  <= step_tick_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign q          = pat_q;
  assign step_tick  = step_tick_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen: a WIDTH=8/DIV=4 instance for
// most scenarios plus a DIV=1 instance for the ping-pong sequence.
module tb_led_pattern_gen;

  logic       clk;
  logic       rs;
  logic       pause, dir;
  logic [1:0] mode;
  logic [7:0] q;
  logic       step_tick, cycle_done;

  logic       pause_f, dir_f;
  logic [1:0] mode_f;
  logic [7:0] q_f;
  logic       step_tick_f, cycle_done_f;

  int errors;
  int checks;

  logic [7:0] left_tab  [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] right_tab [4]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0};
  logic [7:0] dot_tab   [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] pp_tab    [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  led_pattern_gen #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .rs(rs), .pause(pause), .mode(mode), .dir(dir),
    .q(q), .step_tick(step_tick), .cycle_done(cycle_done)
  );

  led_pattern_gen #(.WIDTH(8), .DIV(1)) dut_f (
    .clk(clk), .rs(rs), .pause(pause_f), .mode(mode_f), .dir(dir_f),
    .q(q_f), .step_tick(step_tick_f), .cycle_done(cycle_done_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rs = 1'b0;
    tick();
    rs = 1'b1;
  endtask

  task automatic test_reset();
    rs = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || step_tick !== 1'b0 || cycle_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: q=%h tick=%b done=%b, expected 00 0 0", q, step_tick, cycle_done);
    end
    checks++;
    if (q_f !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_fast: q=%h, expected 00", q_f);
    end
  endtask

  task automatic test_fill_left();
    int ticks, dones, n;
    mode = 2'd0; dir = 1'b0; pause = 1'b0;
    restart();
    ticks = 0; dones = 0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (step_tick) ticks++;
      if (cycle_done) dones++;
      if (c % 4 == 0) begin
        n = c / 4;
        checks++;
        if (q !== left_tab[n-1] || cycle_done !== (n == 16)) begin
          errors++;
          $display("[TB] FAIL fill_left step %0d: q=%h done=%b, expected %h %b",
                   n, q, cycle_done, left_tab[n-1], (n == 16));
        end
      end
    end
    checks++;
    if (ticks != 16 || dones != 1) begin
      errors++;
      $display("[TB] FAIL fill_left_counts: ticks=%0d dones=%0d, expected 16 1", ticks, dones);
    end
  endtask

  task automatic test_fill_right_dir_toggle();
    mode = 2'd0; dir = 1'b1; pause = 1'b0;
    restart();
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 4 == 0) begin
        checks++;
        if (q !== right_tab[c/4-1] || step_tick !== 1'b1) begin
          errors++;
          $display("[TB] FAIL fill_right step %0d: q=%h tick=%b, expected %h 1",
                   c / 4, q, step_tick, right_tab[c/4-1]);
        end
      end
    end
    dir = 1'b0;
    tick();
    checks++;
    if (q !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL dir_no_reload: q=%h, expected F0", q);
    end
    tick(); tick(); tick();
    checks++;
    if (q !== 8'hE0 || step_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dir_toggle_step: q=%h tick=%b, expected E0 1", q, step_tick);
    end
  endtask

  task automatic test_mode_switch();
    int dones;
    mode = 2'd0; dir = 1'b0; pause = 1'b0;
    restart();
    for (int c = 0; c < 16; c++) tick();
    checks++;
    if (q !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL switch_pre: q=%h, expected 0F", q);
    end
    tick(); tick(); tick();
    mode = 2'd1;
    tick();
    checks++;
    if (q !== 8'h01 || step_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_reload: q=%h tick=%b, expected 01 0", q, step_tick);
    end
    dones = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (cycle_done) dones++;
      if (c % 4 == 0) begin
        checks++;
        if (q !== dot_tab[c/4-1] || step_tick !== 1'b1 || cycle_done !== (c == 32)) begin
          errors++;
          $display("[TB] FAIL dot step %0d: q=%h tick=%b done=%b, expected %h 1 %b",
                   c / 4, q, step_tick, cycle_done, dot_tab[c/4-1], (c == 32));
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL dot_done_count: dones=%0d, expected 1", dones);
    end
  endtask

  task automatic test_pingpong();
    int dones;
    mode_f = 2'd2;
    tick();
    checks++;
    if (q_f !== 8'h01 || step_tick_f !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pp_reload: q=%h tick=%b, expected 01 0", q_f, step_tick_f);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (cycle_done_f) dones++;
      checks++;
      if (q_f !== pp_tab[i] || step_tick_f !== 1'b1 || cycle_done_f !== (i == 13)) begin
        errors++;
        $display("[TB] FAIL pp step %0d: q=%h tick=%b done=%b, expected %h 1 %b",
                 i + 1, q_f, step_tick_f, cycle_done_f, pp_tab[i], (i == 13));
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL pp_done_count: dones=%0d, expected 1", dones);
    end
  endtask

  task automatic test_pause();
    pause = 1'b0;
    mode = 2'd3;
    tick();
    checks++;
    if (q !== 8'h00 || step_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blink_reload: q=%h tick=%b, expected 00 0", q, step_tick);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (q !== 8'hFF || step_tick !== 1'b1 || cycle_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blink_on: q=%h tick=%b done=%b, expected FF 1 0", q, step_tick, cycle_done);
    end
    tick(); tick();
    pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (q !== 8'hFF || step_tick !== 1'b0 || cycle_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL pause_hold clk %0d: q=%h tick=%b done=%b, expected FF 0 0",
                 c, q, step_tick, cycle_done);
      end
    end
    pause = 1'b0;
    tick();
    checks++;
    if (q !== 8'hFF || step_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_resume_early: q=%h tick=%b, expected FF 0", q, step_tick);
    end
    tick();
    checks++;
    if (q !== 8'h00 || step_tick !== 1'b1 || cycle_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_resume_step: q=%h tick=%b done=%b, expected 00 1 1",
               q, step_tick, cycle_done);
    end
  endtask

  task automatic test_pause_reload();
    pause = 1'b1;
    mode = 2'd1;
    dir = 1'b1;
    tick();
    checks++;
    if (q !== 8'h80 || step_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pause_reload: q=%h tick=%b, expected 80 0", q, step_tick);
    end
    pause = 1'b0;
    dir = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 2'd0; dir = 1'b0; pause = 1'b0;
    restart();
    for (int c = 0; c < 24; c++) tick();
    checks++;
    if (q !== 8'h3F || step_tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_pre: q=%h tick=%b, expected 3F 1", q, step_tick);
    end
    #2;
    rs = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || step_tick !== 1'b0 || cycle_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: q=%h tick=%b done=%b, expected 00 0 0",
               q, step_tick, cycle_done);
    end
    mode = 2'd1;
    #1;
    rs = 1'b1;
    tick();
    checks++;
    if (q !== 8'h01 || step_tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_release_reload: q=%h tick=%b, expected 01 0", q, step_tick);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rs = 1'b0;
    pause = 1'b0; dir = 1'b0; mode = 2'd0;
    pause_f = 1'b0; dir_f = 1'b0; mode_f = 2'd0;
    test_reset();
    test_fill_left();
    test_fill_right_dir_toggle();
    test_mode_switch();
    test_pingpong();
    test_pause();
    test_pause_reload();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
